// File: rtl/mux_nx1_stream.sv
// N-input registered stream multiplexer: a fixed-select or round-robin grant feeds a
// one-entry valid/ready output register that loads again on the same edge it drains.
module mux_nx1_stream #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [SELW-1:0]  last_grant;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  cand;
  logic             grant_vld;
  logic             load_en;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;

  assign out_valid = (state == FULL);
  assign load_en   = (state == EMPTY) | (out_ready & out_valid);
  assign transfer  = ~reset & load_en & grant_vld;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (!mode) begin
      // Indices >= N never match a channel, so an out-of-range sel yields no grant.
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant     = SELW'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Walk from the farthest candidate back so the nearest one after last_grant wins.
      for (int k = N; k >= 1; k--) begin
        cand = SELW'((int'(last_grant) + k) % N);
        if (in_valid[cand]) begin
          grant     = cand;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = transfer;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SELW'(N - 1);
    end else if (transfer) begin
      state      <= FULL;
      out_data   <= grant_data;
      out_src    <= grant;
      last_grant <= grant;
    end else if (out_valid && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: directed scenarios plus randomized traffic checked by a
// queue scoreboard fed from a grant-rule model; a second N=3 instance covers wrap/range.
module tb_mux_nx1_stream;

  localparam int W = 64;
  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             mode;
  logic [1:0]       sel;
  logic [63:0]      ch [NCH];
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;

  logic             mode3;
  logic [1:0]       sel3;
  logic [23:0]      in_data3;
  logic [2:0]       in_valid3;
  logic [2:0]       in_ready3;
  logic [7:0]       out_data3;
  logic [1:0]       out_src3;
  logic             out_valid3;
  logic             out_ready3;

  assign in_data = {ch[3], ch[2], ch[1], ch[0]};

  always #5 clk = ~clk;

  mux_nx1_stream #(.WIDTH(W), .N(NCH)) u_dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_stream #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          src;
  } exp_t;

  exp_t sbq[$];
  bit   sb_en  = 1'b0;
  bit   m_full = 1'b0;
  int   m_last = NCH - 1;

  // Grant rule: fixed select if in range and valid, else first valid after last grant.
  function automatic int exp_grant(input bit m, input int s, input logic [3:0] v, input int last);
    if (!m) return (s < NCH && v[s] === 1'b1) ? s : -1;
    for (int k = 1; k <= NCH; k++) begin
      if (v[(last + k) % NCH] === 1'b1) return (last + k) % NCH;
    end
    return -1;
  endfunction

  // Model: predicts out_valid, in_ready and pushes each accepted word.
  always begin
    int  g;
    bit  load;
    @(negedge clk);
    #1;
    if (sb_en) begin
      check("sb_valid", 64'(out_valid), 64'(m_full));
      g    = exp_grant(mode, int'(sel), in_valid, m_last);
      load = !m_full || out_ready;
      check("sb_in_ready", 64'(in_ready), (load && g >= 0) ? (64'd1 << g) : 64'd0);
      if (load && g >= 0) begin
        sbq.push_back('{ch[g], g});
        m_last = g;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares the presented word with the oldest expected one, pops on drain.
  always begin
    @(negedge clk);
    #2;
    if (sb_en && out_valid) begin
      check("sb_pending", 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) begin
        check("sb_data", out_data, sbq[0].data);
        check("sb_src", 64'(out_src), 64'(sbq[0].src));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
    ch[0] = 64'h0000_0000_AAAA_0000;
    ch[1] = 64'h1111_2222_3333_4444;
    ch[2] = 64'h0000_0000_DEAD_BEEF;
    ch[3] = 64'h7777_8888_9999_CCCC;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd0);

    // Round-robin with all channels valid: one word per cycle, 0,1,2,3,0,1.
    reset = 1'b0; m_full = 1'b0; m_last = NCH - 1; sb_en = 1'b1;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_src", 64'(out_src), 64'(i % NCH));
      check("rr_valid", 64'(out_valid), 64'd1);
      check("rr_data", out_data, ch[i % NCH]);
    end

    // Backpressure for three edges while holding channel 1's word.
    out_ready = 1'b0;
    #3 check("bp_ready", 64'(in_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bp_src", 64'(out_src), 64'd1);
      check("bp_data", out_data, ch[1]);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_ready_hold", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #3 check("bp_release_ready", 64'(in_ready), 64'b0100);
    @(negedge clk);
    check("bp_next_src", 64'(out_src), 64'd2);

    // Fixed select of channel 2.
    mode = 1'b0; sel = 2'd2;
    #3 check("fix_ready", 64'(in_ready), 64'b0100);
    @(negedge clk);
    check("fix_data", out_data, 64'h0000_0000_DEAD_BEEF);
    check("fix_src", 64'(out_src), 64'd2);
    check("fix_valid", 64'(out_valid), 64'd1);
    in_valid = '0;
    @(negedge clk);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Sparse round-robin from last_grant=3 with channels 0 and 2 valid.
    sel = 2'd3; in_valid = 4'b1000;
    @(negedge clk);
    check("sparse_pre_src", 64'(out_src), 64'd3);
    mode = 1'b1; in_valid = 4'b0101;
    #3 check("sparse_ready0", 64'(in_ready), 64'b0001);
    @(negedge clk);
    check("sparse_src0", 64'(out_src), 64'd0);
    #3 check("sparse_ready1", 64'(in_ready), 64'b0100);
    @(negedge clk);
    check("sparse_src1", 64'(out_src), 64'd2);
    #3 check("sparse_ready2", 64'(in_ready), 64'b0001);
    @(negedge clk);
    check("sparse_src2", 64'(out_src), 64'd0);
    in_valid = '0;

    // Randomized traffic, both modes, random backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NCH; k++) ch[k] = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    check("final_valid", 64'(out_valid), 64'd0);
    sb_en = 1'b0;

    // Asynchronous reset with a word held.
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    ch[1] = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    check("rst_pre_data", out_data, 64'hCAFE_F00D_1234_5678);
    #3 reset = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_data", out_data, 64'd0);
    check("rst_async_src", 64'(out_src), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    reset = 1'b0; in_valid = '0;

    // N=3: out-of-range select never grants; round-robin wraps mod 3.
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in_data3 = {8'h33, 8'h22, 8'h11};
    #3 check("n3_oor_ready", 64'(in_ready3), 64'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("n3_oor_valid", 64'(out_valid3), 64'd0);
      check("n3_oor_ready_hold", 64'(in_ready3), 64'd0);
    end
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("n3_rr_src", 64'(out_src3), 64'(i % 3));
      check("n3_rr_data", 64'(out_data3), 64'(17 * (i % 3 + 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
